fpu_issue_arbiter: RTL and testbench

Shares one pipelined_fpu between NUM_REQ independent requesters (integer core, vector helper, debug port, ...).
- Picks one pending request per cycle, round-robin, and drives it into the FPU issue port, respecting the FPU stall.
- Records the requester ID of every accepted op in an in-order tag FIFO.
- Routes each FPU result back to the requester that issued it.
- Sits directly between the requester ports and the FPU top level.

---
 rtl/fpu_arb_pkg.sv | 36 +++
 rtl/fpu_issue_arbiter_if.sv | 24 ++
 rtl/fpu_tag_fifo.sv | 57 +++++
 rtl/fpu_issue_arbiter.sv | 120 ++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared constants and the round-robin pick helper for the FPU issue arbiter.
package fpu_arb_pkg;

  localparam int OP_W          = 3;
  localparam int DATA_W        = 32;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int MAX_REQ       = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid, searching from ptr+1 upward and wrapping modulo num.
  // Iterating from the farthest candidate down lets the nearest one win last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        num);
    rr_pick_t    r;
    int unsigned cand;
    logic [2:0]  cand3;
    r = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= int'(num)) begin
        cand  = (int'(ptr) + k) % num;
        cand3 = 3'(cand);
        if (valid[cand3]) begin
          r.found = 1'b1;
          r.idx   = cand3;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Requester-side bundle: packed per-requester request lanes plus the shared
// response strobe/data. Requester 0 occupies the LSBs of every packed lane.
interface fpu_issue_arbiter_if #(parameter int NUM_REQ = 4);
  import fpu_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_operand_a;
  logic [NUM_REQ*DATA_W-1:0] req_operand_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_result;

  modport master (
    output req_valid, req_op, req_operand_a, req_operand_b,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_operand_a, req_operand_b,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/fpu_tag_fifo.sv
// In-order FIFO of requester IDs for ops currently inside the FPU.
// full/empty derive from the registered count, so they never depend on
// same-cycle push/pop.
module fpu_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Status flags and the guarded push/pop strobes.
  always_comb begin
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    pop_data = mem[rd_ptr];
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Binary pointers wrap naturally at DEPTH (a power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FPU among NUM_REQ requesters.
// Accepted ops leave their requester ID in an in-order tag FIFO; each FPU
// result pops the head ID and is steered back to that requester with no added
// latency. Optional macro FPU_ARB_PERF_EN adds saturating issue/stall counters.
module fpu_issue_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TAG_DEPTH = TAG_DEPTH_DEF,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  fpu_issue_arbiter_if.slave req_if,
  output logic [OP_W-1:0]   fpu_op,
  output logic              fpu_start,
  output logic [DATA_W-1:0] fpu_operand_a,
  output logic [DATA_W-1:0] fpu_operand_b,
  input  logic              fpu_stall,
  input  logic              fpu_valid,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              busy,
  output logic              tag_error
`ifdef FPU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;
  logic [ID_W-1:0]    grant_id;
  logic               issue;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ID_W-1:0]    head_id;
  logic [CNT_W-1:0]   fifo_count;
  logic               tag_err_q;

  // Grant selection, issue qualification and operand mux from the winner.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_if.req_valid;
    pick                     = rr_pick(valid_ext, 3'(rr_ptr), NUM_REQ);
    grant_id                 = ID_W'(pick.idx);
    issue                    = pick.found & ~fpu_stall & ~fifo_full & ~reset;
    fpu_start                = issue;
    fpu_op                   = '0;
    fpu_operand_a            = '0;
    fpu_operand_b            = '0;
    req_if.req_ready         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.found && (pick.idx == 3'(i))) begin
        fpu_op              = req_if.req_op[i*OP_W +: OP_W];
        fpu_operand_a       = req_if.req_operand_a[i*DATA_W +: DATA_W];
        fpu_operand_b       = req_if.req_operand_b[i*DATA_W +: DATA_W];
        req_if.req_ready[i] = issue;
      end
    end
  end

  // Result routing: the FIFO head names the requester that owns this result.
  always_comb begin
    pop                = fpu_valid & ~fifo_empty & ~reset;
    req_if.resp_valid  = '0;
    req_if.resp_result = fpu_result;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop && (head_id == ID_W'(i))) req_if.resp_valid[i] = 1'b1;
    end
    busy      = (fifo_count != '0) & ~reset;
    tag_error = tag_err_q & ~reset;
  end

  // Round-robin pointer follows the last winner; sticky orphan-result flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      tag_err_q <= 1'b0;
    end else begin
      if (issue) rr_ptr <= grant_id;
      if (fpu_valid && fifo_empty) tag_err_q <= 1'b1;
    end
  end

  fpu_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data (grant_id),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FPU_ARB_PERF_EN
  // Saturating counters: accepted issues, and cycles where work waited.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1))
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_if.req_valid) && !issue && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model. The FPU
// itself is a behavioural stand-in (2-stage pipe, divide stalls stage 2).
module tb_fpu_issue_arbiter;
  import fpu_arb_pkg::*;

  localparam int N         = 4;
  localparam int DEPTH     = 4;
  localparam int OP_ADD    = 0;
  localparam int OP_MUL    = 2;
  localparam int OP_DIV    = 3;
  localparam int DIV_EXTRA = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_operand_a, fpu_operand_b;
  logic        fpu_stall, fpu_valid;
  logic [31:0] fpu_result;
  logic        busy, tag_error;
`ifdef FPU_ARB_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fpu_issue_arbiter_if #(.NUM_REQ(N)) req_if ();

  fpu_issue_arbiter #(.NUM_REQ(N), .TAG_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (req_if),
    .fpu_op        (fpu_op),
    .fpu_start     (fpu_start),
    .fpu_operand_a (fpu_operand_a),
    .fpu_operand_b (fpu_operand_b),
    .fpu_stall     (fpu_stall),
    .fpu_valid     (fpu_valid),
    .fpu_result    (fpu_result),
    .busy          (busy),
    .tag_error     (tag_error)
`ifdef FPU_ARB_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct { int id; logic [31:0] res; } tag_t;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  tag_t tagq[$];
  int   ptr_m;
  logic tag_err_m;
  int   issues_m, stalls_m;
  int   resp_log[$];

  // requester drive state
  logic [N-1:0]    drv_valid;
  logic [N*3-1:0]  drv_op;
  logic [N*32-1:0] drv_a, drv_b;
  int              refill_mode;   // 0 drop on accept, 1 refill ADD, 2 random

  // FPU stand-in
  logic        model_en;
  logic        s1_v, s2_v;
  logic [2:0]  s1_op;
  logic [31:0] s1_a, s1_b, s2_res;
  int          s2_cnt;

  // observations of the last cycle
  logic [N-1:0] obs_ready, obs_rv;
  logic [31:0]  obs_result;
  logic         obs_busy, obs_stall;
  logic         ready_in_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
  endfunction

  task automatic apply_drv();
    req_if.req_valid     = drv_valid;
    req_if.req_op        = drv_op;
    req_if.req_operand_a = drv_a;
    req_if.req_operand_b = drv_b;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    drv_valid[i]      = v;
    drv_op[i*3 +: 3]  = op;
    drv_a[i*32 +: 32] = a;
    drv_b[i*32 +: 32] = b;
    apply_drv();
  endtask

  task automatic rand_req(input int i);
    int r;
    r = $urandom_range(0, 7);
    set_req(i, 1'b1, (r == 7) ? 3'(OP_DIV) : 3'(r % 3), $urandom, $urandom);
  endtask

  task automatic fpu_clear();
    s1_v = 0; s2_v = 0; s2_cnt = 0; s1_op = 0; s1_a = 0; s1_b = 0; s2_res = 0;
    if (model_en) begin fpu_valid = 0; fpu_stall = 0; fpu_result = 0; end
  endtask

  task automatic fpu_step(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (s2_v && s2_cnt != 0) s2_cnt--;
    else begin
      s2_v   = s1_v;
      s2_res = fpu_fn(s1_op, s1_a, s1_b);
      s2_cnt = (s1_v && s1_op == 3'(OP_DIV)) ? DIV_EXTRA : 0;
      s1_v = st; s1_op = op; s1_a = a; s1_b = b;
    end
    fpu_valid  = s2_v && (s2_cnt == 0);
    fpu_stall  = s2_v && (s2_cnt != 0);
    fpu_result = fpu_valid ? s2_res : 32'd0;
  endtask

  // One clock: check at negedge against the model, advance everything after posedge.
  task automatic cycle();
    bit          found, exp_issue, do_pop;
    int          g, idx;
    logic [N-1:0] exp_ready, exp_rv;
    logic        st; logic [2:0] sop; logic [31:0] sa, sb;
    tag_t        ent;
    @(negedge clk);
    found = 0; g = 0; exp_issue = 0; do_pop = 0;
    obs_ready = req_if.req_ready; obs_rv = req_if.resp_valid;
    obs_result = req_if.resp_result; obs_busy = busy; obs_stall = fpu_stall;
    st = fpu_start; sop = fpu_op; sa = fpu_operand_a; sb = fpu_operand_b;
    if (fpu_stall && obs_ready != 0) ready_in_stall = 1;
    if (reset) begin
      chk("rst_ready", obs_ready, 0);
      chk("rst_resp_valid", obs_rv, 0);
      chk("rst_start", st, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_tag_error", tag_error, 0);
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (ptr_m + k) % N;
        if (!found && drv_valid[idx]) begin found = 1; g = idx; end
      end
      exp_issue = found && !fpu_stall && (tagq.size() < DEPTH);
      exp_ready = exp_issue ? N'(1 << g) : '0;
      chk("req_ready", obs_ready, exp_ready);
      chk("fpu_start", st, exp_issue);
      chk("fpu_op", sop, found ? drv_op[g*3 +: 3] : 3'd0);
      chk("fpu_a", sa, found ? drv_a[g*32 +: 32] : 32'd0);
      chk("fpu_b", sb, found ? drv_b[g*32 +: 32] : 32'd0);
      chk("busy", obs_busy, tagq.size() != 0);
      chk("tag_error", tag_error, tag_err_m);
      exp_rv = '0;
      if (fpu_valid && tagq.size() > 0) begin
        do_pop = 1;
        exp_rv = N'(1 << tagq[0].id);
        chk("resp_result", obs_result, model_en ? tagq[0].res : fpu_result);
      end
      chk("resp_valid", obs_rv, exp_rv);
      for (int i = 0; i < N; i++) if (obs_rv[i]) resp_log.push_back(i);
    end
    @(posedge clk); #1;
    if (reset) begin
      tagq.delete(); ptr_m = N - 1; tag_err_m = 0; issues_m = 0; stalls_m = 0;
      fpu_clear();
    end else begin
      if (fpu_valid && tagq.size() == 0) tag_err_m = 1;
      if (do_pop) ent = tagq.pop_front();
      if (exp_issue) begin
        ent.id = g;
        ent.res = fpu_fn(drv_op[g*3 +: 3], drv_a[g*32 +: 32], drv_b[g*32 +: 32]);
        tagq.push_back(ent);
        ptr_m = g;
        issues_m++;
      end else if (drv_valid != 0) stalls_m++;
      if (model_en) fpu_step(st, sop, sa, sb);
    end
    for (int i = 0; i < N; i++) begin
      if (obs_ready[i]) begin
        if (refill_mode == 1) set_req(i, 1'b1, 3'(OP_ADD), $urandom, $urandom);
        else if (refill_mode == 2) begin
          if ($urandom_range(0, 1) == 1) rand_req(i); else set_req(i, 1'b0, 0, 0, 0);
        end else set_req(i, 1'b0, 0, 0, 0);
      end else if (refill_mode == 2 && !drv_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    reset = 1; model_en = 1; refill_mode = 0; ready_in_stall = 0;
    drv_valid = '0; drv_op = '0; drv_a = '0; drv_b = '0; apply_drv();
    tag_err_m = 0; ptr_m = N - 1; issues_m = 0; stalls_m = 0;
    fpu_clear();
    run(2);
    reset = 0;

    // 1: single ADD from requester 2
    set_req(2, 1'b1, 3'(OP_ADD), 32'h3F800000, 32'h40000000);
    cycle();
    chk("t1_ready_T", obs_ready, 4'b0100);
    cycle();
    cycle();
    chk("t1_resp_valid_T2", obs_rv, 4'b0100);
    chk("t1_result_T2", obs_result, fpu_fn(3'(OP_ADD), 32'h3F800000, 32'h40000000));
    cycle();
    chk("t1_busy_T3", obs_busy, 0);

    // 2: all four requesters streaming ADDs; grant order checked by model
    refill_mode = 1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(OP_ADD), $urandom, $urandom);
    resp_log.delete();
    run(12);
    refill_mode = 0; drv_valid = '0; apply_drv();
    run(4);
    chk("t2_resp_count", resp_log.size(), 12);
    if (resp_log.size() >= 5) chk("t2_wrap_grant", resp_log[4], resp_log[0]);

    // 3: DIV from requester 1, then a MUL from requester 0 arriving during the stall
    resp_log.delete(); ready_in_stall = 0;
    set_req(1, 1'b1, 3'(OP_DIV), 32'h40400000, 32'h3F800000);
    cycle(); cycle();
    set_req(0, 1'b1, 3'(OP_MUL), 32'h40000000, 32'h40400000);
    run(12);
    chk("t3_no_ready_in_stall", ready_in_stall, 0);
    chk("t3_resp_count", resp_log.size(), 2);
    if (resp_log.size() >= 2) begin
      chk("t3_div_first", resp_log[0], 1);
      chk("t3_mul_second", resp_log[1], 0);
    end

    // 4: manual FPU, fill the tag FIFO, then pop with a request waiting
    model_en = 0; fpu_stall = 0; fpu_valid = 0; fpu_result = 32'h0;
    refill_mode = 1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(OP_ADD), $urandom, $urandom);
    run(4);
    cycle();
    chk("t4_full_blocks", obs_ready, 0);
    fpu_valid = 1; fpu_result = 32'hCAFE0001;
    cycle();
    chk("t4_pop_same_cycle_no_issue", obs_ready, 0);
    fpu_valid = 0;
    cycle();
    chk("t4_issue_next_cycle", obs_ready != 0, 1);
    refill_mode = 0; drv_valid = '0; apply_drv();
    for (int i = 0; i < DEPTH; i++) begin
      fpu_valid = 1; fpu_result = $urandom; cycle();
    end
    fpu_valid = 0;
    cycle();
    chk("t4_drained", obs_busy, 0);

    // 5: orphan result sets sticky tag_error; reset with ops in flight clears all
    fpu_valid = 1; fpu_result = 32'hDEAD0000;
    cycle();
    chk("t5_orphan_no_resp", obs_rv, 0);
    fpu_valid = 0;
    run(3);
    chk("t5_tag_error_held", tag_error, 1);
    model_en = 1; fpu_clear();
    set_req(0, 1'b1, 3'(OP_ADD), $urandom, $urandom);
    set_req(3, 1'b1, 3'(OP_ADD), $urandom, $urandom);
    cycle(); cycle();
    do_reset();
    cycle();
    chk("t5_busy_after_reset", obs_busy, 0);
    chk("t5_tag_error_after_reset", tag_error, 0);

    // randomized traffic including divides
    refill_mode = 2;
    run(2000);
    refill_mode = 0; drv_valid = '0; apply_drv();
    run(20);
    chk("drain_busy", busy, 0);

`ifdef FPU_ARB_PERF_EN
    // 6: counters since the last reset
    chk("perf_issue_cnt", perf_issue_cnt, issues_m);
    chk("perf_stall_cnt", perf_stall_cnt, stalls_m);
    do_reset();
    model_en = 0; fpu_stall = 0; fpu_valid = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(i % N, 1'b1, 3'(OP_ADD), $urandom, $urandom);
      cycle();
      fpu_valid = 1; cycle(); fpu_valid = 0;
    end
    fpu_stall = 1;
    set_req(1, 1'b1, 3'(OP_ADD), $urandom, $urandom);
    run(3);
    fpu_stall = 0; drv_valid = '0; apply_drv();
    cycle();
    chk("t6_perf_issue_10", perf_issue_cnt, 10);
    chk("t6_perf_stall_3", perf_stall_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
